operand_nibble_loader: RTL and testbench

OPERAND_NIBBLE_LOADER -- requirements
Module: operand_nibble_loader

---
 rtl/operand_nibble_loader_pkg.sv | 50 +++++
 rtl/operand_nibble_loader_phase_timer.sv | 33 +++
 rtl/operand_nibble_loader.sv | 159 +++++++++++++++
 tb/tb_operand_nibble_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_nibble_loader_pkg.sv
// rtl/operand_nibble_loader_pkg.sv - shared states, nibble indices, default timings and helpers
package operand_nibble_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_SETTLE,
        ST_SAMPLE
    } state_t;

    localparam logic [1:0] NIB_A_LO = 2'd0;
    localparam logic [1:0] NIB_A_HI = 2'd1;
    localparam logic [1:0] NIB_B_LO = 2'd2;
    localparam logic [1:0] NIB_B_HI = 2'd3;

    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_PULSE_CYC  = 2;
    localparam int DEF_SETTLE_CYC = 4;

    localparam int TIMER_W = 16;

    // Nibble presented on y for a given index.
    function automatic logic [3:0] nibble_sel(input logic [1:0] idx,
                                              input logic [7:0] op_a,
                                              input logic [7:0] op_b);
        logic [3:0] nib;
        case (idx)
            NIB_A_LO: nib = op_a[3:0];
            NIB_A_HI: nib = op_a[7:4];
            NIB_B_LO: nib = op_b[3:0];
            default:  nib = op_b[7:4];
        endcase
        return nib;
    endfunction

    // One-hot strobe vector {pb4, pb3, pb2, pb1} for a given index.
    function automatic logic [3:0] strobe_vec(input logic [1:0] idx);
        logic [3:0] v;
        case (idx)
            NIB_A_LO: v = 4'b0001;
            NIB_A_HI: v = 4'b0010;
            NIB_B_LO: v = 4'b0100;
            default:  v = 4'b1000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/operand_nibble_loader_phase_timer.sv
// rtl/operand_nibble_loader_phase_timer.sv - phase down-counter shared by all timed states
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the count for a phase of `length` cycles
//   length     : phase length in cycles; 0 behaves as 1
//   expire     : high in the last cycle of the phase
module phase_timer
    import operand_nibble_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] length,
    output logic               expire
);

    logic [TIMER_W-1:0] cnt;

    // Loading length-1 makes a phase of N cycles expire in its N-th cycle;
    // a length of 0 loads 0 and therefore lasts one cycle like length 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (length == '0) ? '0 : length - 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/operand_nibble_loader.sv
// rtl/operand_nibble_loader.sv - loads two 8-bit operands into a comparator nibble by nibble
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start, a, b                 : request and operands, captured when accepted in IDLE
//   less_in, more_in, equal_in  : comparator result lines
//   y                           : nibble bus to the comparator
//   pb1..pb4                    : load strobes for a[3:0], a[7:4], b[3:0], b[7:4]
//   busy, done                  : transaction in progress / one-cycle completion pulse
//   res_less, res_more, res_equal, err : registered result and not-one-hot fault
module operand_nibble_loader
    import operand_nibble_loader_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int PULSE_CYC  = DEF_PULSE_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       less_in,
    input  logic       more_in,
    input  logic       equal_in,
    output logic [3:0] y,
    output logic       pb1,
    output logic       pb2,
    output logic       pb3,
    output logic       pb4,
    output logic       busy,
    output logic       done,
    output logic       res_less,
    output logic       res_more,
    output logic       res_equal,
    output logic       err
);

    localparam logic [TIMER_W-1:0] SETUP_LEN  = TIMER_W'(SETUP_CYC);
    localparam logic [TIMER_W-1:0] PULSE_LEN  = TIMER_W'(PULSE_CYC);
    localparam logic [TIMER_W-1:0] SETTLE_LEN = TIMER_W'(SETTLE_CYC);

    state_t       state, state_d;
    logic [1:0]   idx, idx_d;
    logic [7:0]   a_q, a_d;
    logic [7:0]   b_q, b_d;
    logic [3:0]   pb_q, pb_d;
    logic [3:0]   y_d;
    logic         busy_d, done_d, sample_d;
    logic         timer_load, timer_expire;
    logic [TIMER_W-1:0] timer_len;
    logic         onehot_in;

    phase_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .length (timer_len),
        .expire (timer_expire)
    );

    // Exactly one of three: odd parity rules out 0 and 2 set, the AND rules out 3.
    assign onehot_in = (less_in ^ more_in ^ equal_in) & ~(less_in & more_in & equal_in);

    always_comb begin
        state_d = state;
        idx_d   = idx;
        a_d     = a_q;
        b_d     = b_q;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = NIB_A_LO;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP:  if (timer_expire) state_d = ST_PULSE;
            ST_PULSE:  if (timer_expire) state_d = ST_HOLD;
            ST_HOLD: begin
                if (timer_expire) begin
                    if (idx == NIB_B_HI) begin
                        state_d = ST_SETTLE;
                    end else begin
                        idx_d   = idx + 2'd1;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETTLE: if (timer_expire) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Every timed state is entered from a different state, so a state
        // change is the one and only point where the timer restarts.
        timer_load = (state_d != state);
        case (state_d)
            ST_PULSE:  timer_len = PULSE_LEN;
            ST_SETTLE: timer_len = SETTLE_LEN;
            default:   timer_len = SETUP_LEN;
        endcase

        // Outputs are decoded from the next state and registered, so y and
        // the strobes come straight from flops and cannot glitch.
        y_d = y;
        pb_d = 4'b0000;
        if (state_d == ST_SETUP || state_d == ST_PULSE ||
            state_d == ST_HOLD  || state_d == ST_SETTLE) begin
            y_d = nibble_sel(idx_d, a_d, b_d);
        end
        if (state_d == ST_PULSE) begin
            pb_d = strobe_vec(idx_d);
        end
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_SAMPLE);
        sample_d = (state_d == ST_SAMPLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= NIB_A_LO;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            y         <= 4'h0;
            pb_q      <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_less  <= 1'b0;
            res_more  <= 1'b0;
            res_equal <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            a_q   <= a_d;
            b_q   <= b_d;
            y     <= y_d;
            pb_q  <= pb_d;
            busy  <= busy_d;
            done  <= done_d;
            // Capturing on entry to SAMPLE makes the result valid in the done cycle.
            if (sample_d) begin
                res_less  <= less_in;
                res_more  <= more_in;
                res_equal <= equal_in;
                err       <= ~onehot_in;
            end
        end
    end

    assign pb1 = pb_q[0];
    assign pb2 = pb_q[1];
    assign pb3 = pb_q[2];
    assign pb4 = pb_q[3];

endmodule

// File: tb/tb_operand_nibble_loader.sv
// tb/tb_operand_nibble_loader.sv - directed self-checking bench for operand_nibble_loader
module tb_operand_nibble_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       less_in, more_in, equal_in;
    logic [3:0] y;
    logic       pb1, pb2, pb3, pb4;
    logic       busy, done;
    logic       res_less, res_more, res_equal, err;

    int n_cmp = 0;
    int n_bad = 0;

    logic       mon_en = 1'b0;
    logic       stub_fault = 1'b0;
    logic [3:0] prev_pb = 4'b0000;
    logic [3:0] prev_y = 4'h0;
    logic [3:0] pbv;

    always #5 clk = ~clk;

    assign pbv = {pb4, pb3, pb2, pb1};

    operand_nibble_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .less_in   (less_in),
        .more_in   (more_in),
        .equal_in  (equal_in),
        .y         (y),
        .pb1       (pb1),
        .pb2       (pb2),
        .pb3       (pb3),
        .pb4       (pb4),
        .busy      (busy),
        .done      (done),
        .res_less  (res_less),
        .res_more  (res_more),
        .res_equal (res_equal),
        .err       (err)
    );

    // Comparator model: captures y on each strobe's rising edge.
    logic [3:0] cm_al = 4'h0, cm_ah = 4'h0, cm_bl = 4'h0, cm_bh = 4'h0;
    always @(posedge pb1) cm_al <= y;
    always @(posedge pb2) cm_ah <= y;
    always @(posedge pb3) cm_bl <= y;
    always @(posedge pb4) cm_bh <= y;

    assign less_in  = stub_fault ? 1'b1 : ({cm_ah, cm_al} <  {cm_bh, cm_bl});
    assign more_in  = stub_fault ? 1'b1 : ({cm_ah, cm_al} >  {cm_bh, cm_bl});
    assign equal_in = stub_fault ? 1'b0 : ({cm_ah, cm_al} == {cm_bh, cm_bl});

    // Every-cycle checks: strobes mutually exclusive, y frozen around any strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if ($countones(pbv) > 1) begin
                n_bad++;
                $display("FAIL pb_exclusive t=%0t got pb=%b want at most one high", $time, pbv);
            end
            if (prev_pb != 4'b0000 || pbv != 4'b0000) begin
                n_cmp++;
                if (y !== prev_y) begin
                    n_bad++;
                    $display("FAIL y_stable t=%0t got y=%h want %h", $time, y, prev_y);
                end
            end
            prev_pb = pbv;
        end else begin
            prev_pb = 4'b0000;
        end
        prev_y = y;
    end

    // Called at a negedge with the DUT in IDLE; returns at the negedge of
    // cycle 22 (first IDLE cycle after done).
    task automatic run_trace(input logic [7:0] ta, input logic [7:0] tb_v, input logic hold,
                             input logic [7:0] na, input logic [7:0] nb,
                             input logic el, input logic em, input logic ee, input logic er,
                             input string tag);
        logic [3:0] nib [4];
        logic [3:0] ey, ep;
        int n, p;
        nib[0] = ta[3:0];
        nib[1] = ta[7:4];
        nib[2] = tb_v[3:0];
        nib[3] = tb_v[7:4];
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            if (c <= 16) begin
                n = (c - 1) / 4;
                p = (c - 1) % 4;
                ey = nib[n];
                ep = (p == 1 || p == 2) ? (4'b0001 << n) : 4'b0000;
            end else begin
                ey = nib[3];
                ep = 4'b0000;
            end
            n_cmp++;
            if (pbv !== ep) begin
                n_bad++;
                $display("FAIL %s pb c%0d got %b want %b", tag, c, pbv, ep);
            end
            n_cmp++;
            if (y !== ey) begin
                n_bad++;
                $display("FAIL %s y c%0d got %h want %h", tag, c, y, ey);
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s busy c%0d got %b want 1", tag, c, busy);
            end
            n_cmp++;
            if (done !== (c == 21)) begin
                n_bad++;
                $display("FAIL %s done c%0d got %b want %b", tag, c, done, (c == 21));
            end
            if (c == 21) begin
                n_cmp++;
                if ({res_less, res_more, res_equal, err} !== {el, em, ee, er}) begin
                    n_bad++;
                    $display("FAIL %s result got lme_err=%b want %b", tag,
                             {res_less, res_more, res_equal, err}, {el, em, ee, er});
                end
            end
            if (c == 5) begin
                a = na;
                b = nb;
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s after_done got done,busy=%b want 00", tag, {done, busy});
        end
        n_cmp++;
        if ({res_less, res_more, res_equal, err} !== {el, em, ee, er}) begin
            n_bad++;
            $display("FAIL %s result_hold got %b want %b", tag,
                     {res_less, res_more, res_equal, err}, {el, em, ee, er});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({y, pbv, busy, done, res_less, res_more, res_equal, err} !== 14'b0) begin
            n_bad++;
            $display("FAIL reset_state got y=%h pb=%b busy=%b done=%b res=%b want all 0",
                     y, pbv, busy, done, {res_less, res_more, res_equal, err});
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_5a3c();
        run_trace(8'h5A, 8'h3C, 1'b0, 8'h5A, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, "load_5a3c");
    endtask

    task automatic test_back_to_back();
        run_trace(8'h77, 8'h77, 1'b0, 8'h77, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_first");
        run_trace(8'h77, 8'h77, 1'b0, 8'h77, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_second");
    endtask

    task automatic test_start_held();
        run_trace(8'h12, 8'h34, 1'b1, 8'hAB, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, "held_first");
        run_trace(8'hAB, 8'h3C, 1'b1, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, "held_second");
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL held_release busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        a = 8'h96;
        b = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (pbv !== 4'b0010) begin
            n_bad++;
            $display("FAIL rst_mid pb2_before got %b want 0010", pbv);
        end
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pbv, busy, done, y} !== 10'b0) begin
            n_bad++;
            $display("FAIL rst_mid async got pb=%b busy=%b done=%b y=%h want 0", pbv, busy, done, y);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        run_trace(8'h00, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, "rst_mid_reload");
    endtask

    task automatic test_fault();
        stub_fault = 1'b1;
        run_trace(8'h42, 8'h42, 1'b0, 8'h42, 8'h42, 1'b1, 1'b1, 1'b0, 1'b1, "fault_stub");
        stub_fault = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_5a3c();
        test_back_to_back();
        test_start_held();
        test_reset_mid();
        test_fault();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached got running want finished");
        $fatal(1);
    end

endmodule
